uart_frame_arbiter: RTL and testbench
=====================================

# uart_frame_arbiter

Round-robin scheduler that shares the single 24-bit UART frame transmitter between up to N requesters, such as sensor channels or the OLED command path. It selects one pending requester and latches that requester's 24-bit payload. It then pulses the transmitter's start input and waits for frame completion before acknowledging the requester and serving the next one. It sits between the requester logic and the frame transmitter (enable / send_data / isDone).

## Interface
- N_REQ, default 4: number of requesters, 2..8.
- GAP_CYC, default 16: idle clocks inserted between consecutive frames, 0..255.
- TIMEOUT_CYC, default 2_000_000: watchdog limit in clocks while waiting for completion. Only used when ARB_TIMEOUT_EN is defined.
- clk  in  1: system clock; all logic on the rising edge.
- rst  in  1: synchronous, active-low reset.
- req  in  N_REQ: level request per requester. Held high with data stable until that requester's ack.
- req_data  in  24*N_REQ: payload; requester i uses bits [24*i+23 : 24*i].
- ack  out  N_REQ: one-cycle pulse to the served requester at frame end.
- err  out  1: one-cycle pulse, coincident with ack, when the frame timed out.
- tx_enable  out  1: one-cycle start pulse to the frame transmitter.
- tx_data  out  24: latched payload, stable from grant until the state returns to IDLE.
- tx_done  in  1: transmitter completion flag (isDone); its rising edge marks frame end.
- busy  out  1: high in every state except IDLE.
- cur_id  out  3: index of the granted requester; holds its last value in IDLE.

## Operation
- State machine IDLE → LAUNCH → WAIT → GAP → IDLE.
- IDLE: when any req bit is high, pick the winner by round-robin, starting at index (last_id+1) mod N_REQ.
  - At the same edge: latch req_data of the winner into tx_data, set cur_id, go to LAUNCH.
- LAUNCH: tx_enable=1 for exactly this state, then go to WAIT.
- WAIT: a tx_done rising edge (tx_done=1 with the registered previous value 0) does all of the following at that edge:
  - ack[cur_id] pulses;
  - last_id ← cur_id;
  - go to GAP.
- GAP: count GAP_CYC clocks, then go to IDLE. With GAP_CYC=0, go to IDLE on the next edge.
- Round-robin pointer resets to last_id = N_REQ-1, so index 0 has first priority after reset.
- Requests not high in IDLE are not considered. A req dropped after grant does not abort the frame; ack is still pulsed.
- req_data changes after grant are ignored. tx_data is not updated until the next IDLE grant.
- A tx_done rising edge outside WAIT is ignored. The edge-detect register still updates in every state.
- ack never has more than one bit set. ack and tx_enable are never high in the same cycle.

## Timing
- Reset values of all outputs: ack=0, err=0, tx_enable=0, tx_data=0, busy=0, cur_id=0. Also state=IDLE, gap/timeout counters=0, tx_done history=0.
- Launch latency, with req sampled high at IDLE edge k:
  - tx_enable=1 in cycle k+1;
  - busy=1 from cycle k+1 onward.
- Completion: ack pulses in the cycle after the clock edge that samples the tx_done rising edge.
- Back-to-back: after an ack, the next tx_enable comes no earlier than GAP_CYC+2 cycles later.
- Reset asserted in any state takes effect at the next edge:
  - all outputs go to reset values;
  - the in-flight frame is abandoned with no ack.
  - The transmitter shares rst.

## Configuration
- ARB_TIMEOUT_EN defined:
  - WAIT counts clocks from entry.
  - Reaching TIMEOUT_CYC without a tx_done edge pulses ack[cur_id] and err together, updates last_id, and goes to GAP.
  - The counter clears on WAIT entry.
- ARB_TIMEOUT_EN undefined:
  - no counter is built;
  - WAIT persists until a tx_done edge;
  - err is tied to 0.

## Test plan
- Single request: req=4'b0010, req_data[47:24]=24'hA1B2C3. Expect tx_enable 1 cycle later and tx_data=24'hA1B2C3. Model tx_done high 50 cycles later: ack=4'b0010 pulse, cur_id=1.
- Fairness: all req held high with GAP_CYC=4. Expect grant order 0,1,2,3,0, with ≥6 cycles from each ack to the next tx_enable.
- Pointer rotation: serve id 2, then raise req 1 and 3 together. Expect id 3 granted before id 1.
- Data stability: change req_data of the granted requester during WAIT. tx_data must stay at the latched value until ack.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=100): never drive tx_done. Expect ack and err pulsed together 100 cycles after WAIT entry, then normal service of the next request.
- Reset mid-frame: assert rst low during WAIT for 1 cycle. Expect busy=0, no ack, and next grant to id 0.

Source files
------------

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter sharing one 24-bit UART frame transmitter among N_REQ requesters.
// Optional completion watchdog: define ARB_TIMEOUT_EN (TIMEOUT_CYC clocks in WAIT).
module uart_frame_arbiter #(
    parameter int N_REQ       = 4,
    parameter int GAP_CYC     = 16,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req,
    input  logic [24*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic                err,
    output logic                tx_enable,
    output logic [23:0]         tx_data,
    input  logic                tx_done,
    output logic                busy,
    output logic [2:0]          cur_id,
    output logic [1:0]          dbg_state
);

    // Handshake: a requester holds req high with stable req_data until it sees
    // its one-cycle ack pulse; the transmitter gets a one-cycle tx_enable and
    // reports completion with a rising edge on tx_done.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  last_id;
    logic [7:0]  gap_cnt;
    logic        tx_done_q;
    logic        done_rise;
    logic        gap_done;
    logic        timeout;
    logic [3:0]  pick;
    logic [23:0] win_data;
    logic [N_REQ-1:0] ack_vec;

    // Returns {found, id}; scanning from the farthest candidate down to the
    // nearest one lets the index right after last_id win.
    function automatic logic [3:0] rr_pick(input logic [N_REQ-1:0] r, input logic [2:0] last);
        logic [3:0] res;
        int idx;
        res = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % N_REQ;
            if (r[idx]) res = {1'b1, 3'(idx)};
        end
        return res;
    endfunction

    assign done_rise = tx_done & ~tx_done_q;
    assign gap_done  = (gap_cnt == 8'(GAP_CYC));
    assign tx_enable = (state == S_LAUNCH);
    assign busy      = (state != S_IDLE);
    assign dbg_state = state;

    always_comb begin
        pick     = rr_pick(req, last_id);
        win_data = '0;
        ack_vec  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[2:0] == 3'(i)) win_data = req_data[24*i +: 24];
            if (cur_id == 3'(i))    ack_vec[i] = 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] to_cnt;

    assign timeout = (state == S_WAIT) && (to_cnt == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
        end else if (state == S_WAIT && !timeout) begin
            to_cnt <= to_cnt + TW'(1);
        end else begin
            to_cnt <= '0;
        end
    end
`else
    // No watchdog built; the comparison is constant false.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (pick[3]) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_WAIT;
            S_WAIT:   if (done_rise || timeout) state_nxt = S_GAP;
            S_GAP:    if (gap_done) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            last_id   <= 3'(N_REQ - 1);
            cur_id    <= '0;
            tx_data   <= '0;
            ack       <= '0;
            err       <= 1'b0;
            gap_cnt   <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            tx_done_q <= tx_done;
            ack       <= '0;
            err       <= 1'b0;
            if (state == S_IDLE && pick[3]) begin
                cur_id  <= pick[2:0];
                tx_data <= win_data;
            end
            // A genuine completion edge takes precedence over a coincident timeout.
            if (state == S_WAIT && (done_rise || timeout)) begin
                ack     <= ack_vec;
                err     <= timeout & ~done_rise;
                last_id <= cur_id;
            end
            if (state == S_GAP && !gap_done) begin
                gap_cnt <= gap_cnt + 8'd1;
            end else begin
                gap_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: expected grants/acks are queued by the
// stimulus and popped by a negedge monitor whenever tx_enable or ack appears.
module tb_uart_frame_arbiter;

    localparam int N = 4;
    localparam int G = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TO = 100;
`else
    localparam int TO = 2_000_000;
`endif

    localparam logic [23:0] D0 = 24'h0F0F01;
    localparam logic [23:0] D1 = 24'hA1B2C3;
    localparam logic [23:0] D2 = 24'h5A5A02;
    localparam logic [23:0] D3 = 24'hC0FFEE;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  req = '0;
    logic [24*N-1:0] req_data;
    logic          tx_done = 1'b0;
    logic [N-1:0]  ack;
    logic          err;
    logic          tx_enable;
    logic [23:0]   tx_data;
    logic          busy;
    logic [2:0]    cur_id;
    logic [1:0]    dbg_state;

    uart_frame_arbiter #(
        .N_REQ(N),
        .GAP_CYC(G),
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .req_data(req_data),
        .ack(ack),
        .err(err),
        .tx_enable(tx_enable),
        .tx_data(tx_data),
        .tx_done(tx_done),
        .busy(busy),
        .cur_id(cur_id),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [26:0] exp_grant_q[$];   // {id, data}
    logic [31:0] exp_ack_q[$];     // {err, id, data, ack}

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_grant(input int id, input logic [23:0] d);
        exp_grant_q.push_back({3'(id), d});
    endtask

    task automatic push_ack(input int id, input logic [23:0] d, input logic e);
        logic [N-1:0] a;
        a = '0;
        a[id] = 1'b1;
        exp_ack_q.push_back({e, 3'(id), d, a});
    endtask

    // ---------------- monitor ----------------
    int unsigned last_ack_cyc = 0;
    int unsigned last_en_cyc  = 0;
    bit          seen_ack     = 1'b0;
    logic [31:0] mon_e;

    always @(negedge clk) begin
        if (tx_enable) begin
            last_en_cyc = cyc;
            check("en_ack_overlap", 64'(ack), 64'd0);
            if (seen_ack) check("gap_spacing", 64'(cyc - last_ack_cyc >= G + 2), 64'd1);
            if (exp_grant_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_grant: got id %0d data %0h, no grant expected", cur_id, tx_data);
            end else begin
                mon_e = 32'(exp_grant_q.pop_front());
                check("grant", 64'({cur_id, tx_data}), 64'(mon_e[26:0]));
            end
        end
        if (err) check("err_with_ack", 64'(|ack), 64'd1);
        if (ack != '0) begin
            check("ack_onehot", 64'($onehot(ack)), 64'd1);
            if (exp_ack_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack %0h, no ack expected", ack);
            end else begin
                mon_e = exp_ack_q.pop_front();
                check("ack", 64'({err, cur_id, tx_data, ack}), 64'(mon_e));
            end
            if (err) check("timeout_latency", 64'(cyc - last_en_cyc), 64'(TO + 1));
            last_ack_cyc = cyc;
            seen_ack = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_en(input string name);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (tx_enable) begin
                got = 1'b1;
                break;
            end
        end
        check({name, "_enable_seen"}, 64'(got), 64'd1);
    endtask

    task automatic wait_ack(input string name, input int budget, input bit drop);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                got = 1'b1;
                if (drop) req = req & ~ack;
                break;
            end
        end
        check({name, "_ack_seen"}, 64'(got), 64'd1);
    endtask

    task automatic finish_frame(input string name, input int delay, input bit drop);
        repeat (delay) @(negedge clk);
        tx_done = 1'b1;
        wait_ack(name, 20, drop);
        tx_done = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        req_data = {D3, D2, D1, D0};
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 64'(ack), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_tx_enable", 64'(tx_enable), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_cur_id", 64'(cur_id), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // single request, launch latency, completion 50 cycles later
        push_grant(1, D1);
        push_ack(1, D1, 1'b0);
        req = 4'b0010;
        @(negedge clk);
        check("launch_latency", 64'(tx_enable), 64'd1);
        check("busy_on_launch", 64'(busy), 64'd1);
        finish_frame("single", 50, 1'b1);

        // fairness: fresh pointer, all requests held high
        repeat (8) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            push_grant(k % N, (k % N == 0) ? D0 : (k % N == 1) ? D1 : (k % N == 2) ? D2 : D3);
            push_ack(k % N, (k % N == 0) ? D0 : (k % N == 1) ? D1 : (k % N == 2) ? D2 : D3, 1'b0);
        end
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_en("fair");
            finish_frame("fair", 3 + k, 1'b0);
        end
        req = '0;

        // pointer rotation: serve 2, then 3 must beat 1
        repeat (8) @(negedge clk);
        push_grant(2, D2);
        push_ack(2, D2, 1'b0);
        req = 4'b0100;
        wait_en("rot_a");
        finish_frame("rot_a", 5, 1'b1);
        repeat (8) @(negedge clk);
        push_grant(3, D3);
        push_ack(3, D3, 1'b0);
        push_grant(1, D1);
        push_ack(1, D1, 1'b0);
        req = 4'b1010;
        wait_en("rot_b");
        finish_frame("rot_b", 5, 1'b1);
        wait_en("rot_c");
        finish_frame("rot_c", 5, 1'b1);

        // data stability: payload changes while the frame is in flight
        repeat (8) @(negedge clk);
        push_grant(0, D0);
        push_ack(0, D0, 1'b0);
        req = 4'b0001;
        wait_en("hold");
        repeat (3) @(negedge clk);
        req_data[23:0] = 24'h123456;
        repeat (3) @(negedge clk);
        check("tx_data_hold", 64'(tx_data), 64'(D0));
        finish_frame("hold", 10, 1'b1);
        req_data[23:0] = D0;

`ifdef ARB_TIMEOUT_EN
        // watchdog: tx_done never rises
        repeat (8) @(negedge clk);
        push_grant(2, D2);
        push_ack(2, D2, 1'b1);
        req = 4'b0100;
        wait_en("timeout");
        wait_ack("timeout", 300, 1'b1);
        push_grant(0, D0);
        push_ack(0, D0, 1'b0);
        req = 4'b0001;
        wait_en("after_timeout");
        finish_frame("after_timeout", 5, 1'b1);
`endif

        // reset during WAIT abandons the frame; pointer restarts at 0
        repeat (8) @(negedge clk);
        push_grant(1, D1);
        req = 4'b0011;
        wait_en("abort");
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_ack", 64'(ack), 64'd0);
        check("mid_rst_tx_enable", 64'(tx_enable), 64'd0);
        check("mid_rst_cur_id", 64'(cur_id), 64'd0);
        check("mid_rst_tx_data", 64'(tx_data), 64'd0);
        push_grant(0, D0);
        push_ack(0, D0, 1'b0);
        push_grant(1, D1);
        push_ack(1, D1, 1'b0);
        wait_en("post_rst0");
        finish_frame("post_rst0", 5, 1'b1);
        wait_en("post_rst1");
        finish_frame("post_rst1", 5, 1'b1);

        // ---------------- final report ----------------
        repeat (20) @(negedge clk);
        check("grant_q_drained", 64'(exp_grant_q.size()), 64'd0);
        check("ack_q_drained", 64'(exp_ack_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
